// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the system-bus round-robin arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } arb_state_e;

  localparam int M_SPI  = 0;
  localparam int M_DMEM = 1;
  localparam int M_DMA  = 2;

  localparam int NUM_MASTERS_DEF = 3;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational winner selection: optional master-0 priority, else first
// requester after rr_ptr in circular order.
module bus_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  excl,
  input  logic [IW-1:0] rr_ptr,
  input  logic          hipri,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  w_avail;
  logic [IW-1:0] w_cand [N];

  assign w_avail = req & ~excl;

  // w_cand[gi] is the index visited at scan offset gi+1 from rr_ptr
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] w_sum;
    assign w_sum        = {1'b0, rr_ptr} + (IW+1)'(gi + 1);
    assign w_cand[gi]   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  end

  always_comb begin
    valid = |w_avail;
    idx   = '0;
    if (!(hipri && w_avail[0])) begin
      // Walk backwards so the smallest offset is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
        if (w_avail[w_cand[i]]) idx = w_cand[i];
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with burst-limit handoff and optional master-0 priority.
// Define BUS_ARB_TIMEOUT_EN to add stall-timeout revocation with a sticky exclusion mask.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = NUM_MASTERS_DEF,
  parameter int MAX_BURST      = 16,
  parameter int HIPRI_M0       = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_MASTERS-1:0]         req_i,
  input  logic                           beat_i,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  output logic [$clog2(NUM_MASTERS)-1:0] gnt_id_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int NM = NUM_MASTERS;
  localparam int IW = $clog2(NM);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;

  arb_state_e    r_state, w_state_next;
  logic [IW-1:0] r_owner, w_owner_next;
  logic [IW-1:0] r_rr_ptr, w_rr_next;
  logic [BW-1:0] r_beat_cnt, w_beat_next;
  logic [NM-1:0] r_gnt, w_gnt_next;
  logic          r_busy;
  logic [NM-1:0] w_own_bit, w_excl, w_mask;
  logic          w_pick_valid;
  logic [IW-1:0] w_pick_idx, w_grant_idx;
  logic          w_new_grant, w_tmo_fire;

  function automatic logic [NM-1:0] f_onehot(input logic [IW-1:0] i);
    logic [NM-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign w_own_bit = f_onehot(r_owner);
  // Outside IDLE the current owner never competes in its own replacement pick.
  assign w_excl    = (r_state == IDLE) ? w_mask : (w_mask | w_own_bit);

  bus_rr_pick #(.N(NM)) u_pick (
    .req    (req_i),
    .excl   (w_excl),
    .rr_ptr (r_rr_ptr),
    .hipri  (HIPRI_M0 != 0),
    .valid  (w_pick_valid),
    .idx    (w_pick_idx)
  );

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_rr_next    = r_rr_ptr;
    w_beat_next  = r_beat_cnt;
    w_gnt_next   = r_gnt;
    w_new_grant  = 1'b0;
    w_grant_idx  = w_pick_idx;
    case (r_state)
      IDLE: w_new_grant = w_pick_valid;
      GRANT: begin
        if (!req_i[r_owner]) begin
          if (w_pick_valid) begin
            w_new_grant = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_gnt_next   = '0;
          end
        end else if (beat_i) begin
          if (MAX_BURST != 0) begin
            if (r_beat_cnt == LAST_BEAT) begin
              w_beat_next = '0;
              if (w_pick_valid) begin
                w_state_next = HANDOFF;
                w_gnt_next   = '0;
              end
            end else begin
              w_beat_next = r_beat_cnt + 1'b1;
            end
          end
        end else if (w_tmo_fire) begin
          w_state_next = HANDOFF;
          w_gnt_next   = '0;
        end
      end
      HANDOFF: begin
        if (w_pick_valid) begin
          w_new_grant = 1'b1;
        end else if (req_i[r_owner] && !w_mask[r_owner]) begin
          w_new_grant = 1'b1;
          w_grant_idx = r_owner;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
      end
    endcase
    if (w_new_grant) begin
      w_state_next = GRANT;
      w_owner_next = w_grant_idx;
      w_rr_next    = w_grant_idx;
      w_beat_next  = '0;
      w_gnt_next   = f_onehot(w_grant_idx);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= IW'(NM - 1);
      r_beat_cnt <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_rr_ptr   <= w_rr_next;
      r_beat_cnt <= w_beat_next;
      r_gnt      <= w_gnt_next;
      r_busy     <= |w_gnt_next;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SW-1:0] r_stall_cnt;
  logic [NM-1:0] r_mask;
  logic          r_timeout;

  assign w_tmo_fire = (r_state == GRANT) && req_i[r_owner] && !beat_i &&
                      (r_stall_cnt == SW'(TIMEOUT_CYCLES - 1));
  assign w_mask     = r_mask;
  assign timeout_o  = r_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_mask      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= w_tmo_fire;
      // A revoked master stays excluded until it drops its request.
      r_mask    <= (r_mask | (w_tmo_fire ? w_own_bit : '0)) & req_i;
      if (w_new_grant || (r_state == GRANT && beat_i)) begin
        r_stall_cnt <= '0;
      end else if (r_state == GRANT && !w_tmo_fire) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end
`else
  assign w_tmo_fire = 1'b0;
  assign w_mask     = '0;
  assign timeout_o  = 1'b0;
`endif

  assign gnt_o    = r_gnt;
  assign gnt_id_o = r_owner;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: a pure round-robin and a master-0-priority instance
// share one stimulus stream and are each checked every cycle against a model.
module tb_bus_rr_arbiter;

  localparam int NM   = 3;
  localparam int MAXB = 4;
  localparam int TMO  = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       beat = 1'b0;

  logic [2:0] gnt_rr, gnt_hp;
  logic [1:0] id_rr, id_hp;
  logic       busy_rr, busy_hp, tmo_rr, tmo_hp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.NUM_MASTERS(NM), .MAX_BURST(MAXB), .HIPRI_M0(0), .TIMEOUT_CYCLES(TMO)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .beat_i(beat),
    .gnt_o(gnt_rr), .gnt_id_o(id_rr), .busy_o(busy_rr), .timeout_o(tmo_rr)
  );

  bus_rr_arbiter #(.NUM_MASTERS(NM), .MAX_BURST(MAXB), .HIPRI_M0(1), .TIMEOUT_CYCLES(TMO)) u_hp (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .beat_i(beat),
    .gnt_o(gnt_hp), .gnt_id_o(id_hp), .busy_o(busy_hp), .timeout_o(tmo_hp)
  );

  // Model: st 0 = idle, 1 = owning, 2 = one-cycle gap before the next owner.
  typedef struct packed {
    int         st;
    int         owner;
    int         bcnt;
    int         rr;
    int         stall;
    logic [2:0] mask;
    logic       tmo;
  } mdl_t;

  mdl_t m_rr, m_hp;

  function automatic mdl_t m_reset();
    mdl_t s;
    s.st = 0; s.owner = 0; s.bcnt = 0; s.rr = NM - 1; s.stall = 0;
    s.mask = 3'b000; s.tmo = 1'b0;
    return s;
  endfunction

  function automatic int m_pick(logic [2:0] avail, int rr, bit hp);
    if (hp && avail[0]) return 0;
    for (int off = 1; off <= NM; off++) begin
      int j;
      j = (rr + off) % NM;
      if (avail[j]) return j;
    end
    return -1;
  endfunction

  function automatic mdl_t m_grant(mdl_t s, int w);
    mdl_t n;
    n = s;
    n.st = 1; n.owner = w; n.rr = w; n.bcnt = 0; n.stall = 0;
    return n;
  endfunction

  function automatic mdl_t m_step(mdl_t s, logic [2:0] r, logic b, bit hp);
    mdl_t       n;
    logic [2:0] kb, others;
    int         w;
    n      = s;
    n.tmo  = 1'b0;
    kb     = 3'b001 << s.owner;
    others = r & ~s.mask & ~kb;
    if (s.st == 0) begin
      w = m_pick(r & ~s.mask, s.rr, hp);
      if (w >= 0) n = m_grant(s, w);
    end else if (s.st == 1) begin
      if (!r[s.owner]) begin
        w = m_pick(others, s.rr, hp);
        if (w >= 0) n = m_grant(s, w);
        else n.st = 0;
      end else if (b) begin
        n.stall = 0;
        n.bcnt  = s.bcnt + 1;
        if (n.bcnt == MAXB) begin
          n.bcnt = 0;
          if (others != 3'b000) n.st = 2;
        end
      end else if (TMO_EN && s.stall == TMO - 1) begin
        n.tmo  = 1'b1;
        n.st   = 2;
        n.mask = s.mask | kb;
      end else begin
        n.stall = s.stall + 1;
      end
    end else begin
      w = m_pick(others, s.rr, hp);
      if (w >= 0) n = m_grant(s, w);
      else if (r[s.owner] && !s.mask[s.owner]) n = m_grant(s, s.owner);
      else n.st = 0;
    end
    n.mask = n.mask & r;
    return n;
  endfunction

  function automatic logic [2:0] exp_gnt(mdl_t s);
    return (s.st == 1) ? (3'b001 << s.owner) : 3'b000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr <= m_reset();
      m_hp <= m_reset();
    end else begin
      m_rr <= m_step(m_rr, req, beat, 1'b0);
      m_hp <= m_step(m_hp, req, beat, 1'b1);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string nm, input mdl_t s, input logic [2:0] g,
                          input logic [1:0] id, input logic bz, input logic tm);
    chk({nm, ".gnt"}, int'(g), int'(exp_gnt(s)));
    chk({nm, ".busy"}, int'(bz), int'(s.st == 1));
    chk({nm, ".timeout"}, int'(tm), int'(s.tmo));
    if (s.st == 1) chk({nm, ".id"}, int'(id), s.owner);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      cmp_inst("rr", m_rr, gnt_rr, id_rr, busy_rr, tmo_rr);
      cmp_inst("hp", m_hp, gnt_hp, id_hp, busy_hp, tmo_hp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    int  exp_owner;
    fork
      compare_loop();
    join_none

    #12;
    chk("reset.gnt_rr", int'(gnt_rr), 0);
    chk("reset.busy_rr", int'(busy_rr), 0);
    chk("reset.id_rr", int'(id_rr), 0);
    chk("reset.tmo_rr", int'(tmo_rr), 0);
    chk("reset.gnt_hp", int'(gnt_hp), 0);
    rst_n = 1'b1;
    tick();

    // Basic grant and release
    req = 3'b010;
    tick();
    chk("basic.gnt_rr", int'(gnt_rr), 2);
    chk("basic.id_rr", int'(id_rr), 1);
    chk("basic.gnt_hp", int'(gnt_hp), 2);
    repeat (3) tick();
    req = 3'b000;
    tick();
    chk("basic.release_gnt", int'(gnt_rr), 0);
    chk("basic.release_busy", int'(busy_rr), 0);

    // Asynchronous reset mid-tenure, between clock edges
    req = 3'b010;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("areset.gnt_rr", int'(gnt_rr), 0);
    chk("areset.busy_rr", int'(busy_rr), 0);
    chk("areset.gnt_hp", int'(gnt_hp), 0);
    chk("areset.busy_hp", int'(busy_hp), 0);
    req = 3'b000;
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Round-robin fairness: all request, owner releases for one cycle after 2 beats
    req = 3'b111;
    tick();
    for (int i = 0; i < 6; i++) begin
      exp_owner = i % NM;
      chk("rr.order", int'(id_rr), exp_owner);
      chk("rr.no_bubble", int'(busy_rr), 1);
      beat = 1'b1;
      tick();
      tick();
      beat = 1'b0;
      req = 3'b111 & ~(3'b001 << exp_owner);
      tick();
      req = 3'b111;
    end
    req = 3'b000;
    repeat (3) tick();

    // Master 0 priority never preempts, but wins the next arbitration
    req = 3'b100;
    tick();
    chk("prio.dma_owns", int'(id_hp), 2);
    req = 3'b111;
    tick();
    chk("prio.no_preempt1", int'(id_hp), 2);
    tick();
    chk("prio.no_preempt2", int'(gnt_hp), 4);
    req = 3'b011;
    tick();
    chk("prio.next_is_0", int'(id_hp), 0);
    chk("prio.next_busy", int'(busy_hp), 1);
    req = 3'b010;
    tick();
    chk("prio.then_1", int'(id_hp), 1);
    req = 3'b000;
    repeat (2) tick();

    // Burst limit with another master waiting
    req = 3'b010;
    tick();
    req = 3'b110;
    beat = 1'b1;
    repeat (3) tick();
    chk("burst.still_owner", int'(gnt_rr), 2);
    tick();
    chk("burst.handoff_gnt", int'(gnt_rr), 0);
    chk("burst.handoff_busy", int'(busy_rr), 0);
    beat = 1'b0;
    tick();
    chk("burst.new_owner_rr", int'(gnt_rr), 4);
    chk("burst.new_owner_hp", int'(gnt_hp), 4);
    req = 3'b000;
    repeat (2) tick();

    // Burst limit with nobody waiting: grant kept, counter restarts
    req = 3'b010;
    tick();
    beat = 1'b1;
    repeat (4) tick();
    chk("burst_alone.kept", int'(gnt_rr), 2);
    req = 3'b110;
    repeat (3) tick();
    chk("burst_alone.cnt_restart", int'(gnt_rr), 2);
    tick();
    chk("burst_alone.handoff", int'(gnt_rr), 0);
    beat = 1'b0;
    tick();
    chk("burst_alone.dma", int'(gnt_rr), 4);
    req = 3'b000;
    repeat (2) tick();

    // Stall timeout
    req = 3'b100;
    tick();
    req = 3'b110;
    n = 0;
    seen = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    while (!seen && n < 20) begin
      tick();
      n++;
      if (tmo_rr) seen = 1'b1;
    end
    chk("tmo.latency", n, TMO);
    chk("tmo.gnt_off", int'(gnt_rr), 0);
    chk("tmo.pulse_hp", int'(tmo_hp), 1);
    tick();
    chk("tmo.single_pulse", int'(tmo_rr), 0);
    chk("tmo.dmem_owns", int'(gnt_rr), 2);
    req = 3'b100;
    tick();
    chk("tmo.masked_idle", int'(gnt_rr), 0);
    tick();
    chk("tmo.still_masked", int'(busy_rr), 0);
    req = 3'b000;
    tick();
    req = 3'b100;
    tick();
    chk("tmo.eligible_again", int'(gnt_rr), 4);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tmo_rr || tmo_hp) seen = 1'b1;
    end
    chk("tmo.never", int'(seen), 0);
    chk("tmo.grant_kept", int'(gnt_rr), 4);
`endif
    req = 3'b000;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
